fft_demap: RTL and testbench
============================

FFT_DEMAP -- requirements
Module: fft_demap

Interface
REQ-001 Parameter IN_DW, default 21: width of each real/imag input component from the FFT core.
REQ-002 Parameter OUT_DW, default 16: width of each real/imag output component.
REQ-003 Parameter LGNFFT, default 8: log2 of FFT size; NFFT=2**LGNFFT, HALF=NFFT/2.
REQ-004 Parameter RSHIFT, default 5: right shift applied before rounding and saturation.
REQ-005 i_clk  in  1  single clock; all logic rising-edge.
REQ-006 i_reset_n  in  1  asynchronous, active-low reset.
REQ-007 i_ce  in  1  input beat strobe; i_data and i_sync are sampled only when i_ce=1.
REQ-008 i_data  in  2*IN_DW  FFT bin, bit-reversal-corrected order; real in upper half, imag in lower half, two's complement.
REQ-009 i_sync  in  1  marks bin 0 of a frame (qualified by i_ce).
REQ-010 i_sc_start  in  LGNFFT  first shifted subcarrier index to emit.
REQ-011 i_sc_count  in  LGNFFT+1  number of subcarriers to emit (0..NFFT).
REQ-012 o_valid  out  1  output sample valid; no backpressure.
REQ-013 o_data  out  2*OUT_DW  scaled sample, same packing as i_data.
REQ-014 o_sc  out  LGNFFT  shifted index s of o_data (s=0 is bin -HALF).
REQ-015 o_first / o_last  out  1 each  first / last emitted sample of a window.
REQ-016 o_sync_err  out  1  one-clock pulse on misaligned i_sync.

Function
REQ-017 A bin counter b SHALL increment on each i_ce beat, wrap NFFT-1 to 0, and be forced so the beat carrying i_sync is b=0.
REQ-018 States: WAIT_SYNC (ignore data), FIRST (beats b=0..HALF-1 of first frame after sync, write only), RUN.
REQ-019 WAIT_SYNC -> FIRST on i_ce&i_sync; FIRST -> RUN on the beat b=HALF; RUN persists across frames.
REQ-020 Beats b<HALF SHALL be written into ping-pong bank W at address b; W toggles at each b=0.
REQ-021 In RUN, a beat b>=HALF SHALL produce output s=b-HALF directly; a beat b<HALF SHALL produce output s=b+HALF read from bank !W at address b (previous frame).
REQ-022 Output order per frame is thus s=0..NFFT-1 (natural frequency order); buffered half delayed exactly NFFT beats.
REQ-023 Data pipeline advances only on i_ce, depth 2 beats for both paths; o_valid high for exactly one clock per emitted beat.
REQ-024 i_sc_start and i_sc_count SHALL be latched when s=0 is processed and held for that output frame.
REQ-025 Emit only when start<=s<start+count and s<=NFFT-1; o_first at s=start, o_last at s=min(start+count,NFFT)-1; count=0 emits nothing.
REQ-026 Scaling per component: add 2**(RSHIFT-1), arithmetic shift right RSHIFT, saturate to [-2**(OUT_DW-1), 2**(OUT_DW-1)-1].
REQ-027 i_sync with b!=0 (RUN or FIRST) SHALL pulse o_sync_err, realign b=0, enter FIRST, discard pipeline contents; the truncated window gets no o_last.
REQ-028 Counter wrap without i_sync SHALL be treated as a valid frame start (no error).
REQ-029 o_valid, o_first, o_last, o_sync_err are 0 when not asserted by REQ-023..027.

Reset
REQ-030 i_reset_n low SHALL asynchronously force WAIT_SYNC, b=0, W=0, pipeline valids 0, all outputs 0.
REQ-031 Buffer RAM contents SHALL NOT be reset; FIRST guarantees no stale read reaches the output.

Structure
REQ-032 Shared package holds state enum and the round/saturate width constants; parameters stay module-level.
REQ-033 One sub-module, demap_pingpong_ram: two HALF x 2*IN_DW banks, one write port, one registered read port.

Verification
REQ-034 Reset, then sync + frames of bin b = (b, -b): first output only in frame 2, s=0 equals bin 128 (>>5 rounded), order 128..255,0..127.
REQ-035 start=8, count=240: 240 valids per frame, o_first at s=8, o_last at s=247, o_sc contiguous.
REQ-036 Input real = +1048575 and -1048576: o_data real = +32767 and -32768; input 48 -> 2, input 47 -> 1.
REQ-037 i_sync at b=100 mid-RUN: one o_sync_err pulse, no o_last for that window, outputs resume one half-frame later.
REQ-038 i_ce toggled 1-in-3 randomly: output sequence identical to continuous-i_ce run.
REQ-039 i_reset_n asserted mid-frame: outputs 0 immediately, no valid until a new sync plus HALF+2 beats.

Source files
------------

// File: rtl/fft_demap_pkg.sv
// Shared types and default widths for the FFT demapper.
package fft_demap_pkg;

  typedef enum logic [1:0] {
    ST_WAIT_SYNC = 2'd0,
    ST_FIRST     = 2'd1,
    ST_RUN       = 2'd2
  } state_e;

  localparam int unsigned DEF_IN_DW  = 21;
  localparam int unsigned DEF_OUT_DW = 16;
  localparam int unsigned DEF_LGNFFT = 8;
  localparam int unsigned DEF_RSHIFT = 5;

  // One extra bit so the rounding add can never overflow the input range.
  localparam int unsigned RND_GUARD_W = 1;

endpackage

// File: rtl/fft_demap_if.sv
// Beat stream from the FFT core in, demapped subcarrier stream out.
interface fft_demap_if
  import fft_demap_pkg::*;
#(
  parameter int unsigned IN_DW  = DEF_IN_DW,
  parameter int unsigned OUT_DW = DEF_OUT_DW,
  parameter int unsigned LGNFFT = DEF_LGNFFT
);
  logic                  i_ce;
  logic [2*IN_DW-1:0]    i_data;
  logic                  i_sync;
  logic [LGNFFT-1:0]     i_sc_start;
  logic [LGNFFT:0]       i_sc_count;
  logic                  o_valid;
  logic [2*OUT_DW-1:0]   o_data;
  logic [LGNFFT-1:0]     o_sc;
  logic                  o_first;
  logic                  o_last;
  logic                  o_sync_err;

  modport master (
    output i_ce, i_data, i_sync, i_sc_start, i_sc_count,
    input  o_valid, o_data, o_sc, o_first, o_last, o_sync_err
  );

  modport slave (
    input  i_ce, i_data, i_sync, i_sc_start, i_sc_count,
    output o_valid, o_data, o_sc, o_first, o_last, o_sync_err
  );
endinterface

// File: rtl/fft_demap_pingpong_ram.sv
// Two half-frame banks addressed as {bank, addr}; one write port, one registered read port.
module demap_pingpong_ram #(
  parameter int unsigned DW = 42,
  parameter int unsigned AW = 7
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic          i_wbank,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_re,
  input  logic          i_rbank,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);
  localparam int unsigned DEPTH = 2 << AW;

  logic [DW-1:0] mem [DEPTH];

  // Storage is deliberately not reset; the read register only updates on a read.
  always_ff @(posedge i_clk) begin
    if (i_we) mem[{i_wbank, i_waddr}] <= i_wdata;
    if (i_re) o_rdata <= mem[{i_rbank, i_raddr}];
  end
endmodule

// File: rtl/fft_demap.sv
// Reorders FFT bins into natural frequency order, selects a subcarrier window
// and rounds/saturates each component to OUT_DW bits.
module fft_demap
  import fft_demap_pkg::*;
#(
  parameter int unsigned IN_DW  = DEF_IN_DW,
  parameter int unsigned OUT_DW = DEF_OUT_DW,
  parameter int unsigned LGNFFT = DEF_LGNFFT,
  parameter int unsigned RSHIFT = DEF_RSHIFT
) (
  input logic        i_clk,
  input logic        i_reset_n,
  fft_demap_if.slave bus
);
  localparam int unsigned NFFT  = 1 << LGNFFT;
  localparam int unsigned HALF  = NFFT / 2;
  localparam int unsigned AW    = LGNFFT - 1;
  localparam int unsigned DW    = 2 * IN_DW;
  localparam int unsigned EW    = LGNFFT + 2;
  localparam int unsigned SUM_W = IN_DW + RND_GUARD_W;
  localparam int unsigned SHR_W = SUM_W - RSHIFT;
  localparam logic [LGNFFT-1:0] HALF_B = LGNFFT'(HALF);
  localparam logic [EW-1:0]     NFFT_E = EW'(NFFT);
  localparam logic [SUM_W-1:0]  RND    = SUM_W'(1) << (RSHIFT - 1);

  function automatic logic [OUT_DW-1:0] sat_round(input logic [IN_DW-1:0] x);
    logic signed [SUM_W-1:0] sum;
    logic [SHR_W-1:0]        shr;
    logic [SHR_W-OUT_DW:0]   top;
    sum = $signed({x[IN_DW-1], x}) + $signed(RND);
    shr = SHR_W'(sum >>> RSHIFT);
    top = shr[SHR_W-1:OUT_DW-1];
    if ((&top) || !(|top))  sat_round = shr[OUT_DW-1:0];
    else if (shr[SHR_W-1])  sat_round = {1'b1, {(OUT_DW-1){1'b0}}};
    else                    sat_round = {1'b0, {(OUT_DW-1){1'b1}}};
  endfunction

  state_e            state_q, state_d;
  logic [LGNFFT-1:0] b_q, b_eff, s_c;
  logic              w_q, w_eff;
  logic              sync_err, run_beat, wr_en, rd_en;
  logic [LGNFFT-1:0] start_q, win_start;
  logic [LGNFFT:0]   count_q, win_count;
  logic [EW-1:0]     win_end, win_stop;
  logic              emit, first_c, last_c;
  logic              s1_valid, s1_first, s1_last, s1_ram;
  logic [LGNFFT-1:0] s1_sc;
  logic [DW-1:0]     s1_data, ram_rdata, din_c;

  // The beat carrying i_sync is always bin 0.
  assign b_eff = bus.i_sync ? '0 : b_q;
  assign w_eff = w_q ^ (bus.i_ce && (b_eff == '0));
  assign s_c   = {~b_eff[LGNFFT-1], b_eff[AW-1:0]};

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) state_q <= ST_WAIT_SYNC;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    sync_err = 1'b0;
    if (bus.i_ce) begin
      unique case (state_q)
        ST_WAIT_SYNC: if (bus.i_sync) state_d = ST_FIRST;
        ST_FIRST: begin
          if (bus.i_sync && (b_q != '0)) sync_err = 1'b1;
          else if (b_eff == HALF_B)      state_d  = ST_RUN;
        end
        ST_RUN: begin
          if (bus.i_sync && (b_q != '0)) begin
            sync_err = 1'b1;
            state_d  = ST_FIRST;
          end
        end
        default: state_d = ST_WAIT_SYNC;
      endcase
    end
  end

  assign run_beat = bus.i_ce && !sync_err &&
                    ((state_q == ST_RUN) || ((state_q == ST_FIRST) && (b_eff == HALF_B)));
  assign wr_en    = bus.i_ce && !b_eff[LGNFFT-1] && ((state_q != ST_WAIT_SYNC) || bus.i_sync);
  assign rd_en    = bus.i_ce && !b_eff[LGNFFT-1];

  // Window parameters are taken live at s=0 and held for the rest of that output frame.
  assign win_start = (s_c == '0) ? bus.i_sc_start : start_q;
  assign win_count = (s_c == '0) ? bus.i_sc_count : count_q;
  assign win_end   = EW'(win_start) + EW'(win_count);
  assign win_stop  = (win_end > NFFT_E) ? NFFT_E : win_end;
  assign emit      = run_beat && (s_c >= win_start) && (EW'(s_c) < win_end);
  assign first_c   = (s_c == win_start);
  assign last_c    = ((EW'(s_c) + EW'(1)) == win_stop);

  demap_pingpong_ram #(.DW(DW), .AW(AW)) u_ram (
    .i_clk   (i_clk),
    .i_we    (wr_en),
    .i_wbank (w_eff),
    .i_waddr (b_eff[AW-1:0]),
    .i_wdata (bus.i_data),
    .i_re    (rd_en),
    .i_rbank (~w_eff),
    .i_raddr (b_eff[AW-1:0]),
    .o_rdata (ram_rdata)
  );

  assign din_c = s1_ram ? ram_rdata : s1_data;

  // Two-beat pipeline: stage 1 tags the beat, stage 2 scales and presents it.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      b_q            <= '0;
      w_q            <= 1'b0;
      start_q        <= '0;
      count_q        <= '0;
      s1_valid       <= 1'b0;
      s1_first       <= 1'b0;
      s1_last        <= 1'b0;
      s1_ram         <= 1'b0;
      s1_sc          <= '0;
      s1_data        <= '0;
      bus.o_valid    <= 1'b0;
      bus.o_data     <= '0;
      bus.o_sc       <= '0;
      bus.o_first    <= 1'b0;
      bus.o_last     <= 1'b0;
      bus.o_sync_err <= 1'b0;
    end else begin
      bus.o_valid    <= 1'b0;
      bus.o_first    <= 1'b0;
      bus.o_last     <= 1'b0;
      bus.o_sync_err <= 1'b0;
      if (bus.i_ce) begin
        b_q <= b_eff + LGNFFT'(1);
        w_q <= w_eff;
        if (run_beat && (s_c == '0)) begin
          start_q <= bus.i_sc_start;
          count_q <= bus.i_sc_count;
        end
        s1_valid       <= emit;
        s1_first       <= first_c;
        s1_last        <= last_c;
        s1_ram         <= ~b_eff[LGNFFT-1];
        s1_sc          <= s_c;
        s1_data        <= bus.i_data;
        bus.o_sync_err <= sync_err;
        if (s1_valid && !sync_err) begin
          bus.o_valid <= 1'b1;
          bus.o_first <= s1_first;
          bus.o_last  <= s1_last;
          bus.o_sc    <= s1_sc;
          bus.o_data  <= {sat_round(din_c[DW-1:IN_DW]), sat_round(din_c[IN_DW-1:0])};
        end
      end
    end
  end
endmodule

// File: tb/tb_fft_demap.sv
// Scoreboard bench for fft_demap: directed frames, expected samples queued ahead of the DUT.
module tb_fft_demap;
  localparam int unsigned IN_DW  = 21;
  localparam int unsigned OUT_DW = 16;
  localparam int unsigned LGNFFT = 8;
  localparam int unsigned RSHIFT = 5;
  localparam int          NFFT   = 256;
  localparam int          HALF   = 128;

  typedef struct packed {
    logic [LGNFFT-1:0]   sc;
    logic [2*OUT_DW-1:0] data;
    logic                first;
    logic                last;
  } exp_t;

  logic i_clk;
  logic rst_n;
  fft_demap_if #(.IN_DW(IN_DW), .OUT_DW(OUT_DW), .LGNFFT(LGNFFT)) bus ();

  fft_demap #(.IN_DW(IN_DW), .OUT_DW(OUT_DW), .LGNFFT(LGNFFT), .RSHIFT(RSHIFT)) dut (
    .i_clk     (i_clk),
    .i_reset_n (rst_n),
    .bus       (bus.slave)
  );

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   n_first = 0, n_last = 0, n_serr = 0;
  int   beats_done = 0;
  int   lat_base = 0, lat = -1;
  bit   lat_armed = 0;

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  function automatic int pre(input int tag, input int b);
    if (tag == 0) return b;
    if (tag == 9) begin
      case (b)
        128: return 1048575;
        129: return -1048576;
        130: return 48;
        131: return 47;
        default: return 0;
      endcase
    end
    return b * 37 + tag * 1001 - 6000;
  endfunction

  function automatic int pim(input int tag, input int b);
    if (tag == 0) return -b;
    if (tag == 9) begin
      case (b)
        128: return 47;
        129: return 48;
        130: return -1048576;
        131: return 1048575;
        default: return 0;
      endcase
    end
    return tag * 500 - b * 29;
  endfunction

  function automatic int scale_ref(input int x);
    int y;
    y = (x + 16) >>> 5;
    if (y > 32767)  y = 32767;
    if (y < -32768) y = -32768;
    return y;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Queue the samples of the output window built from frame 'tag', up to s_hi.
  task automatic expect_window(input int tag, input int st, input int cnt, input int s_hi);
    exp_t x;
    int   e;
    e = st + cnt;
    if (e > NFFT) e = NFFT;
    for (int s = st; (s < e) && (s <= s_hi); s++) begin
      int bin;
      bin     = (s < HALF) ? s + HALF : s - HALF;
      x.sc    = LGNFFT'(s);
      x.data  = {OUT_DW'(scale_ref(pre(tag, bin))), OUT_DW'(scale_ref(pim(tag, bin)))};
      x.first = (s == st);
      x.last  = (s == e - 1);
      q.push_back(x);
    end
  endtask

  task automatic push_const(input int s, input logic [31:0] d, input bit f, input bit l);
    exp_t x;
    x.sc    = LGNFFT'(s);
    x.data  = d;
    x.first = f;
    x.last  = l;
    q.push_back(x);
  endtask

  task automatic beat(input int tag, input int b, input bit sync, input bit gaps);
    if (gaps) begin
      while ($urandom_range(0, 2) != 32'd0) begin
        @(posedge i_clk);
        #1;
      end
    end
    bus.i_ce   = 1'b1;
    bus.i_sync = sync;
    bus.i_data = {IN_DW'(pre(tag, b)), IN_DW'(pim(tag, b))};
    @(posedge i_clk);
    beats_done++;
    #1;
    bus.i_ce   = 1'b0;
    bus.i_sync = 1'b0;
  endtask

  task automatic frame(input int tag, input int nb, input bit sync, input bit gaps);
    for (int b = 0; b < nb; b++) beat(tag, b, sync && (b == 0), gaps);
  endtask

  // Sync frame, full frames, then a final frame cut just after its mid-point.
  task automatic stream(input int tag0, input int nfr, input bit gaps);
    for (int f = 0; f < nfr; f++) frame(tag0 + f, (f == nfr - 1) ? HALF + 1 : NFFT, f == 0, gaps);
  endtask

  task automatic scen_begin(input int st, input int cnt);
    bus.i_sc_start = LGNFFT'(st);
    bus.i_sc_count = (LGNFFT + 1)'(cnt);
    n_first = 0;
    n_last  = 0;
    n_serr  = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    @(posedge i_clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic scen_end(input string name, input int ef, input int el, input int es);
    repeat (3) begin
      @(posedge i_clk);
      #1;
    end
    chk({name, "_drain"}, 64'(q.size()), 64'd0);
    chk({name, "_first_cnt"}, 64'(n_first), 64'(ef));
    chk({name, "_last_cnt"}, 64'(n_last), 64'(el));
    chk({name, "_sync_err_cnt"}, 64'(n_serr), 64'(es));
    q.delete();
    do_reset();
  endtask

  // Monitor: every presented sample is matched against the head of the queue.
  initial begin
    exp_t act, x;
    forever begin
      @(negedge i_clk);
      if (rst_n) begin
        if (bus.o_sync_err) n_serr++;
        if (bus.o_valid) begin
          if (bus.o_first) n_first++;
          if (bus.o_last)  n_last++;
          if (lat_armed) begin
            lat       = beats_done - lat_base;
            lat_armed = 0;
          end
          act.sc    = bus.o_sc;
          act.data  = bus.o_data;
          act.first = bus.o_first;
          act.last  = bus.o_last;
          checks++;
          if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_valid: got sc=%0d data=%h, expected no output", act.sc, act.data);
          end else begin
            x = q.pop_front();
            if (act !== x) begin
              errors++;
              $display("FAIL sample: got sc=%0d data=%h first=%b last=%b, expected sc=%0d data=%h first=%b last=%b",
                       act.sc, act.data, act.first, act.last, x.sc, x.data, x.first, x.last);
            end
          end
        end
      end
    end
  end

  initial begin
    bus.i_ce       = 1'b0;
    bus.i_sync     = 1'b0;
    bus.i_data     = '0;
    bus.i_sc_start = '0;
    bus.i_sc_count = '0;
    rst_n          = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    chk("rst_valid", 64'(bus.o_valid), 64'd0);
    chk("rst_data", 64'(bus.o_data), 64'd0);
    chk("rst_sc", 64'(bus.o_sc), 64'd0);
    chk("rst_first", 64'(bus.o_first), 64'd0);
    chk("rst_last", 64'(bus.o_last), 64'd0);
    chk("rst_sync_err", 64'(bus.o_sync_err), 64'd0);
    rst_n = 1'b1;
    @(posedge i_clk);
    #1;

    // Full band, natural order, (b,-b) pattern in the sync frame
    scen_begin(0, 256);
    expect_window(0, 0, 256, 255);
    expect_window(1, 0, 256, 255);
    stream(0, 3, 0);
    scen_end("full", 2, 2, 0);

    // Interior window 8..247
    scen_begin(8, 240);
    expect_window(1, 8, 240, 255);
    expect_window(2, 8, 240, 255);
    stream(1, 3, 0);
    scen_end("win8", 2, 2, 0);

    // Window running past the top bin clamps at s=255
    scen_begin(200, 100);
    expect_window(3, 200, 100, 255);
    stream(3, 2, 0);
    scen_end("clamp", 1, 1, 0);

    // Empty window
    scen_begin(5, 0);
    stream(5, 3, 0);
    scen_end("empty", 0, 0, 0);

    // Rounding and saturation, hand-computed
    scen_begin(0, 4);
    push_const(0, {16'h7fff, 16'h0001}, 1'b1, 1'b0);
    push_const(1, {16'h8000, 16'h0002}, 1'b0, 1'b0);
    push_const(2, {16'h0002, 16'h8000}, 1'b0, 1'b0);
    push_const(3, {16'h0001, 16'h7fff}, 1'b0, 1'b1);
    stream(9, 2, 0);
    scen_end("sat", 1, 1, 0);

    // Sparse i_ce gives the same sequence as the continuous run
    scen_begin(0, 256);
    expect_window(0, 0, 256, 255);
    expect_window(1, 0, 256, 255);
    stream(0, 3, 1);
    scen_end("gaps", 2, 2, 0);

    // Misaligned sync at b=100: window truncated at s=226, no o_last
    scen_begin(0, 256);
    expect_window(3, 0, 256, 226);
    expect_window(5, 0, 256, 255);
    frame(3, NFFT, 1, 0);
    frame(4, 100, 0, 0);
    frame(5, NFFT, 1, 0);
    frame(6, HALF + 1, 0, 0);
    scen_end("sync_err", 2, 1, 1);

    // Reset in mid-frame, then first valid exactly HALF+2 beats after a new sync
    scen_begin(0, 256);
    expect_window(7, 0, 256, 176);
    frame(7, NFFT, 1, 0);
    frame(8, 50, 0, 0);
    @(negedge i_clk);
    #1;
    chk("pre_reset_valid", 64'(bus.o_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(bus.o_valid), 64'd0);
    chk("mid_rst_data", 64'(bus.o_data), 64'd0);
    chk("mid_rst_sc", 64'(bus.o_sc), 64'd0);
    chk("mid_rst_flags", 64'({bus.o_first, bus.o_last, bus.o_sync_err}), 64'd0);
    chk("mid_rst_drain", 64'(q.size()), 64'd0);
    chk("mid_rst_first_cnt", 64'(n_first), 64'd1);
    chk("mid_rst_last_cnt", 64'(n_last), 64'd0);
    q.delete();
    @(posedge i_clk);
    #1;
    rst_n = 1'b1;
    scen_begin(0, 256);
    expect_window(10, 0, 256, 255);
    lat_base  = beats_done;
    lat       = -1;
    lat_armed = 1;
    frame(10, NFFT, 1, 0);
    frame(11, HALF + 1, 0, 0);
    scen_end("after_rst", 1, 1, 0);
    chk("resync_latency", 64'(lat), 64'(HALF + 2));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
